// File: rtl/ibex_fetch_fifo_wide.sv
// Instruction fetch FIFO for a 32/64-bit fetch bus: stores whole bus words, realigns
// 16/32-bit instructions at any halfword offset and bypasses the bus word when empty.
module ibex_fetch_fifo_wide #(
    parameter int unsigned NUM_REQS = 2,
    parameter int unsigned BUS_W    = 32,
    parameter bit          ResetAll = 1'b0,
    localparam int unsigned DEPTH   = NUM_REQS + 1,
    localparam int unsigned LVL_W   = $clog2(DEPTH + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear_i,
    output logic [NUM_REQS-1:0] busy_o,
    output logic [LVL_W-1:0]    level_o,
    input  logic                in_valid_i,
    input  logic [31:0]         in_addr_i,
    input  logic [BUS_W-1:0]    in_rdata_i,
    input  logic                in_err_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [31:0]         out_addr_o,
    output logic [31:0]         out_rdata_o,
    output logic                out_err_o,
    output logic                out_err_plus2_o
);

    localparam int unsigned HW    = BUS_W / 16;
    localparam int unsigned OFS_W = $clog2(HW);
    localparam logic [OFS_W-1:0] OFS_LAST = OFS_W'(HW - 1);
    localparam logic [OFS_W-1:0] OFS_PEN  = OFS_W'(HW - 2);

    // Three copies of every state register; all readers see the majority vote.
    logic [DEPTH-1:0] valid_q [3];
    logic [DEPTH-1:0] err_q   [3];
    logic [30:0]      pc_q    [3];
    logic [BUS_W-1:0] rdata_q [3][DEPTH];

    logic [DEPTH-1:0] valid_v, err_v;
    logic [30:0]      pc_v;
    logic [BUS_W-1:0] rdata_v [DEPTH];

    logic [DEPTH-1:0] valid_d, err_d;
    logic [30:0]      pc_d;
    logic [BUS_W-1:0] rdata_d [DEPTH];

    always_comb begin
        valid_v = (valid_q[0] & valid_q[1]) | (valid_q[0] & valid_q[2]) | (valid_q[1] & valid_q[2]);
        err_v   = (err_q[0] & err_q[1]) | (err_q[0] & err_q[2]) | (err_q[1] & err_q[2]);
        pc_v    = (pc_q[0] & pc_q[1]) | (pc_q[0] & pc_q[2]) | (pc_q[1] & pc_q[2]);
        for (int i = 0; i < DEPTH; i++) begin
            rdata_v[i] = (rdata_q[0][i] & rdata_q[1][i]) | (rdata_q[0][i] & rdata_q[2][i]) |
                         (rdata_q[1][i] & rdata_q[2][i]);
        end
    end

    logic [BUS_W-1:0] head_word, next_word;
    logic             head_err, next_err, head_present, next_present;
    logic [OFS_W-1:0] ofs, ofs_nxt;
    logic [15:0]      head_hw [HW];
    logic [15:0]      low_hw, up_hw;
    logic             is_last, compressed, accept, pop;

    assign head_word    = valid_v[0] ? rdata_v[0] : in_rdata_i;
    assign head_err     = valid_v[0] ? err_v[0]   : in_err_i;
    assign head_present = valid_v[0] | in_valid_i;
    assign next_word    = valid_v[1] ? rdata_v[1] : in_rdata_i;
    assign next_err     = valid_v[1] ? err_v[1]   : in_err_i;
    assign next_present = valid_v[1] | (valid_v[0] & in_valid_i);

    assign ofs     = pc_v[OFS_W-1:0];
    assign ofs_nxt = ofs + OFS_W'(1);
    assign is_last = (ofs == OFS_LAST);

    always_comb begin
        for (int i = 0; i < HW; i++) begin
            head_hw[i] = head_word[16*i +: 16];
        end
    end

    // The upper half of an instruction starting in the last halfword comes from the next word.
    assign low_hw     = head_hw[ofs];
    assign up_hw      = is_last ? next_word[15:0] : head_hw[ofs_nxt];
    assign compressed = (low_hw[1:0] != 2'b11) & ~head_err;

    assign out_valid_o     = head_present & (compressed | ~is_last | next_present);
    assign out_rdata_o     = {up_hw, low_hw};
    assign out_addr_o      = {pc_v, 1'b0};
    assign out_err_o       = head_err | (is_last & ~compressed & next_err);
    assign out_err_plus2_o = is_last & ~compressed & next_err & ~head_err;

    assign accept = out_valid_o & out_ready_i;
    assign pop    = accept & (compressed ? is_last : (is_last | (ofs == OFS_PEN)));

    // Push into the lowest free slot first, then shift down on pop, so a bypassed
    // word consumed entirely this cycle drops out of the FIFO again.
    logic [DEPTH-1:0] push_sel, valid_p, err_p;
    logic [BUS_W-1:0] rdata_p [DEPTH];
    logic             below_valid;

    always_comb begin
        below_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            push_sel[i] = in_valid_i & ~valid_v[i] & below_valid;
            below_valid = below_valid & valid_v[i];
            valid_p[i]  = valid_v[i] | push_sel[i];
            err_p[i]    = push_sel[i] ? in_err_i   : err_v[i];
            rdata_p[i]  = push_sel[i] ? in_rdata_i : rdata_v[i];
        end
    end

    always_comb begin
        valid_d = valid_p;
        err_d   = err_p;
        pc_d    = pc_v;
        for (int i = 0; i < DEPTH; i++) begin
            rdata_d[i] = rdata_p[i];
        end
        if (clear_i) begin
            valid_d = '0;
            err_d   = err_v;
            pc_d    = in_addr_i[31:1];
            for (int i = 0; i < DEPTH; i++) begin
                rdata_d[i] = rdata_v[i];
            end
        end else begin
            if (accept) begin
                pc_d = pc_v + (compressed ? 31'd1 : 31'd2);
            end
            if (pop) begin
                valid_d = {1'b0, valid_p[DEPTH-1:1]};
                err_d   = {err_p[DEPTH-1], err_p[DEPTH-1:1]};
                for (int i = 0; i < DEPTH - 1; i++) begin
                    rdata_d[i] = rdata_p[i+1];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int c = 0; c < 3; c++) begin
            if (!rst_ni) begin
                valid_q[c] <= '0;
                pc_q[c]    <= '0;
            end else begin
                valid_q[c] <= valid_d;
                pc_q[c]    <= pc_d;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int c = 0; c < 3; c++) begin
            if (ResetAll && !rst_ni) begin
                err_q[c] <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    rdata_q[c][i] <= '0;
                end
            end else begin
                err_q[c] <= err_d;
                for (int i = 0; i < DEPTH; i++) begin
                    rdata_q[c][i] <= rdata_d[i];
                end
            end
        end
    end

    always_comb begin
        level_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            level_o = level_o + LVL_W'(valid_v[i]);
        end
    end

    assign busy_o = valid_v[DEPTH-1 -: NUM_REQS];

    logic unused_addr0;
    assign unused_addr0 = in_addr_i[0];

    a_bus_w: assert property (@(posedge clk_i) (BUS_W == 32) || (BUS_W == 64));
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(in_valid_i && valid_v[DEPTH-1] && !clear_i));

endmodule
